// File: rtl/toy_dtcm_arbiter_if.sv
// Bundle of the two requester ports, their read-response ports and the DTCM memory port.
interface toy_dtcm_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned SB_WIDTH   = 10
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  rq0_valid;
  logic                  rq0_ready;
  logic [ADDR_WIDTH-1:0] rq0_addr;
  logic                  rq0_wr_en;
  logic [DATA_WIDTH-1:0] rq0_wr_data;
  logic [BE_WIDTH-1:0]   rq0_wr_byte_en;
  logic [SB_WIDTH-1:0]   rq0_sideband;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic [SB_WIDTH-1:0]   rsp0_sideband;

  logic                  rq1_valid;
  logic                  rq1_ready;
  logic [ADDR_WIDTH-1:0] rq1_addr;
  logic                  rq1_wr_en;
  logic [DATA_WIDTH-1:0] rq1_wr_data;
  logic [BE_WIDTH-1:0]   rq1_wr_byte_en;
  logic [SB_WIDTH-1:0]   rq1_sideband;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;
  logic [SB_WIDTH-1:0]   rsp1_sideband;

  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [BE_WIDTH-1:0]   mem_wr_byte_en;
  logic [SB_WIDTH-1:0]   mem_req_sideband;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [SB_WIDTH-1:0]   mem_ack_sideband;

  modport slave (
    input  rq0_valid, rq0_addr, rq0_wr_en, rq0_wr_data, rq0_wr_byte_en, rq0_sideband,
    input  rq1_valid, rq1_addr, rq1_wr_en, rq1_wr_data, rq1_wr_byte_en, rq1_sideband,
    output rq0_ready, rq1_ready,
    output rsp0_valid, rsp0_data, rsp0_sideband,
    output rsp1_valid, rsp1_data, rsp1_sideband,
    output mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_wr_byte_en, mem_req_sideband,
    input  mem_rd_data, mem_ack_sideband
  );

  modport master (
    output rq0_valid, rq0_addr, rq0_wr_en, rq0_wr_data, rq0_wr_byte_en, rq0_sideband,
    output rq1_valid, rq1_addr, rq1_wr_en, rq1_wr_data, rq1_wr_byte_en, rq1_sideband,
    input  rq0_ready, rq1_ready,
    input  rsp0_valid, rsp0_data, rsp0_sideband,
    input  rsp1_valid, rsp1_data, rsp1_sideband,
    input  mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_wr_byte_en, mem_req_sideband,
    output mem_rd_data, mem_ack_sideband
  );
endinterface

// File: rtl/toy_dtcm_arbiter.sv
// Two-port DTCM arbiter: port 0 has priority, port 1 is forced through after
// STARVE_LIMIT denied cycles; the 1-cycle read response is routed to its issuer.
module toy_dtcm_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned SB_WIDTH     = 10,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             rst_n,
  toy_dtcm_arbiter_if.slave bus
);
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       force1;
  logic       gnt0;
  logic       gnt1;
  logic       rd_pend;
  logic       rd_sel;
  logic       rd_issue;

  // Grants are held off while in reset so every output reads 0 then.
  always_comb begin
    force1 = (starve_cnt == STARVE_MAX);
    gnt1   = rst_n & bus.rq1_valid & (~bus.rq0_valid | force1);
    gnt0   = rst_n & bus.rq0_valid & ~gnt1;
  end

  assign bus.rq0_ready = gnt0;
  assign bus.rq1_ready = gnt1;

  // Memory port mux; idle fields are zeroed rather than left floating.
  always_comb begin
    bus.mem_en           = 1'b0;
    bus.mem_addr         = ADDR_WIDTH'(0);
    bus.mem_wr_en        = 1'b0;
    bus.mem_wr_data      = DATA_WIDTH'(0);
    bus.mem_wr_byte_en   = BE_WIDTH'(0);
    bus.mem_req_sideband = SB_WIDTH'(0);
    if (gnt0) begin
      bus.mem_en           = 1'b1;
      bus.mem_addr         = bus.rq0_addr;
      bus.mem_wr_en        = bus.rq0_wr_en;
      bus.mem_wr_data      = bus.rq0_wr_data;
      bus.mem_wr_byte_en   = bus.rq0_wr_byte_en;
      bus.mem_req_sideband = bus.rq0_sideband;
    end else if (gnt1) begin
      bus.mem_en           = 1'b1;
      bus.mem_addr         = bus.rq1_addr;
      bus.mem_wr_en        = bus.rq1_wr_en;
      bus.mem_wr_data      = bus.rq1_wr_data;
      bus.mem_wr_byte_en   = bus.rq1_wr_byte_en;
      bus.mem_req_sideband = bus.rq1_sideband;
    end
  end

  // Counts consecutive denied cycles of port 1; any break in contention restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
    end else if (gnt1 || !bus.rq1_valid) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= 8'(starve_cnt + 8'd1);
    end
  end

  assign rd_issue = bus.mem_en & ~bus.mem_wr_en;

  // Remember who issued the read so next cycle's data goes back to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_sel  <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_sel <= gnt1;
      end
    end
  end

  assign bus.rsp0_valid    = rd_pend & ~rd_sel;
  assign bus.rsp1_valid    = rd_pend & rd_sel;
  assign bus.rsp0_data     = bus.mem_rd_data;
  assign bus.rsp1_data     = bus.mem_rd_data;
  assign bus.rsp0_sideband = bus.mem_ack_sideband;
  assign bus.rsp1_sideband = bus.mem_ack_sideband;
endmodule

// File: tb/tb_toy_dtcm_arbiter.sv
// Scoreboard bench for toy_dtcm_arbiter: directed grant checks plus a response monitor.
module tb_toy_dtcm_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = 10;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toy_dtcm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SW)) bus ();

  toy_dtcm_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SW), .STARVE_LIMIT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic          port;
    logic [SW-1:0] sb;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {4{a ^ 32'hDEAD_0000}};
  endfunction

  function automatic logic [DW-1:0] wdat(input logic [AW-1:0] a);
    return {4{a ^ 32'h1234_5678}};
  endfunction

  function automatic logic [BW-1:0] wbe(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: fixed 1-cycle read latency, data derived from the address.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_wr_en) begin
      bus.mem_rd_data      <= pat(bus.mem_addr);
      bus.mem_ack_sideband <= bus.mem_req_sideband;
    end
  end

  // Response monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        chk("rsp_both_valid", DW'(1'b1), DW'(1'b0));
      end else if (exp_q.size() == 0) begin
        chk("rsp_unexpected", DW'(bus.rsp1_valid), DW'(1'b0));
        checks--;
        errors += (bus.rsp1_valid ? 0 : 1);
        checks++;
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_port", DW'(bus.rsp1_valid), DW'(mon_e.port));
        chk("rsp_sideband", DW'(bus.rsp1_valid ? bus.rsp1_sideband : bus.rsp0_sideband),
            DW'(mon_e.sb));
        chk("rsp_data", bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data, mon_e.data);
      end
    end
  end

  task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0,
                       input logic [SW-1:0] s0, input logic v1, input logic w1,
                       input logic [AW-1:0] a1, input logic [SW-1:0] s1);
    bus.rq0_valid      = v0;
    bus.rq0_wr_en      = w0;
    bus.rq0_addr       = a0;
    bus.rq0_wr_data    = wdat(a0);
    bus.rq0_wr_byte_en = wbe(a0);
    bus.rq0_sideband   = s0;
    bus.rq1_valid      = v1;
    bus.rq1_wr_en      = w1;
    bus.rq1_addr       = a1;
    bus.rq1_wr_data    = wdat(a1);
    bus.rq1_wr_byte_en = wbe(a1);
    bus.rq1_sideband   = s1;
  endtask

  // One cycle: drive, check grant and memory drive mid-cycle, queue the expected read.
  task automatic step(input logic v0, input logic w0, input logic [AW-1:0] a0,
                      input logic [SW-1:0] s0, input logic v1, input logic w1,
                      input logic [AW-1:0] a1, input logic [SW-1:0] s1,
                      input logic e0, input logic e1, input bit push);
    logic          ew;
    logic [AW-1:0] ea;
    logic [SW-1:0] es;
    rsp_t          r;
    drive(v0, w0, a0, s0, v1, w1, a1, s1);
    @(negedge clk);
    chk("rq0_ready", DW'(bus.rq0_ready), DW'(e0));
    chk("rq1_ready", DW'(bus.rq1_ready), DW'(e1));
    chk("mem_en", DW'(bus.mem_en), DW'(e0 | e1));
    ew = e0 ? w0 : (e1 ? w1 : 1'b0);
    ea = e0 ? a0 : (e1 ? a1 : '0);
    es = e0 ? s0 : (e1 ? s1 : '0);
    chk("mem_wr_en", DW'(bus.mem_wr_en), DW'(ew));
    chk("mem_addr", DW'(bus.mem_addr), DW'(ea));
    chk("mem_req_sideband", DW'(bus.mem_req_sideband), DW'(es));
    if (e0 || e1) begin
      chk("mem_wr_data", bus.mem_wr_data, wdat(ea));
      chk("mem_wr_byte_en", DW'(bus.mem_wr_byte_en), DW'(wbe(ea)));
      if (push && !ew) begin
        r.port = e1;
        r.sb   = es;
        r.data = pat(ea);
        exp_q.push_back(r);
      end
    end else begin
      chk("mem_wr_data_idle", bus.mem_wr_data, DW'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_rq0_ready", DW'(bus.rq0_ready), DW'(0));
    chk("rst_rq1_ready", DW'(bus.rq1_ready), DW'(0));
    chk("rst_mem_en", DW'(bus.mem_en), DW'(0));
    chk("rst_mem_addr", DW'(bus.mem_addr), DW'(0));
    chk("rst_rsp0_valid", DW'(bus.rsp0_valid), DW'(0));
    chk("rst_rsp1_valid", DW'(bus.rsp1_valid), DW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic g1;
    logic [AW-1:0] a1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    bus.mem_rd_data      = '0;
    bus.mem_ack_sideband = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with both ports requesting, then release: port 0 wins immediately.
    drive(1'b1, 1'b0, 32'h100, 10'h001, 1'b1, 1'b0, 32'h200, 10'h002);
    chk_reset_outputs();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h100, 10'h001, 1'b1, 1'b0, 32'h200, 10'h002, 1'b1, 1'b0, 1'b1);
    idle();

    // Single port-0 read.
    step(1'b1, 1'b0, 32'h40, 10'h015, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle();

    // Continuous contention: 8 grants to port 0 then one to port 1, twice.
    for (int i = 0; i < 18; i++) begin
      g1 = (i % 9 == 8);
      a1 = (i < 9) ? 32'h2000 : 32'h2010;
      step(1'b1, 1'b0, 32'(32'h1000 + 16 * i), 10'(10'h020 + i),
           1'b1, 1'b0, a1, (i < 9) ? 10'h3F0 : 10'h3F1, ~g1, g1, 1'b1);
    end
    idle();

    // Port 1 read, port 0 write, port 1 read.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h300, 10'h031, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h310, 10'h032, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h320, 10'h033, 1'b0, 1'b1, 1'b1);
    idle();
    idle();

    // Port 1 contends 5 cycles, drops 1, then needs 8 more denials before force.
    for (int i = 0; i < 15; i++) begin
      g1 = (i == 14);
      step(1'b1, 1'b1, 32'(32'h400 + 16 * i), 10'h040,
           (i != 5), 1'b0, 32'h500, 10'h051, ~g1, g1, 1'b1);
    end
    idle();

    // Read in flight when reset hits: its response must never appear.
    step(1'b1, 1'b0, 32'h600, 10'h061, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h610, 10'h062, 1'b1, 1'b0, 32'h700, 10'h071);
    chk_reset_outputs();
    chk_reset_outputs();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h610, 10'h062, 1'b1, 1'b0, 32'h700, 10'h071, 1'b1, 1'b0, 1'b1);
    idle();
    idle();

    chk("pending_responses", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
